// File: rtl/fp_pkg.sv
// Shared definitions for the pipelined floating-point multiplier.
//   fp_class_e : operand classification produced by fp_unpack
//   FLG_*      : bit positions inside the 3-bit exception flag vector
//   fp_bias()  : exponent bias for a given exponent width
//   fp_qnan()  : canonical quiet NaN pattern (LSB-aligned, caller truncates)
package fp_pkg;

  typedef enum logic [1:0] {
    FP_ZERO,
    FP_NORM,
    FP_INF,
    FP_NAN
  } fp_class_e;

  localparam int FLG_INV = 2;
  localparam int FLG_OVF = 1;
  localparam int FLG_UDF = 0;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // sign 0, exponent all-ones, fraction MSB set, remaining fraction bits 0
  function automatic logic [127:0] fp_qnan(input int exp_w, input int man_w);
    logic [127:0] q;
    q = '0;
    for (int i = 0; i < exp_w; i++) q[man_w + i] = 1'b1;
    q[man_w - 1] = 1'b1;
    return q;
  endfunction

endpackage

// File: rtl/fp_unpack.sv
// Combinational operand unpacker for fp_mul_pipe.
// Ports:
//   op    : packed operand {sign, exp, frac}
//   sign  : sign bit
//   expo  : biased exponent field
//   sig   : significand with hidden bit restored, {1, frac}
//   cls   : ZERO (exp==0, denormals flushed), INF, NAN or NORM
module fp_unpack
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [EXP_W+MAN_W:0] op,
  output logic                 sign,
  output logic [EXP_W-1:0]     expo,
  output logic [MAN_W:0]       sig,
  output fp_class_e            cls
);

  logic [EXP_W-1:0] e;
  logic [MAN_W-1:0] f;

  always_comb begin
    sign = op[EXP_W+MAN_W];
    e    = op[EXP_W+MAN_W-1:MAN_W];
    f    = op[MAN_W-1:0];
    expo = e;
    sig  = {1'b1, f};
    if (e == '0) begin
      cls = FP_ZERO;
    end else if (&e) begin
      cls = (f == '0) ? FP_INF : FP_NAN;
    end else begin
      cls = FP_NORM;
    end
  end

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined floating-point multiplier with valid/ready handshake.
//   S1 unpack/classify, S2 significand multiply, S3 normalise/round/pack.
// Ports:
//   clk, rst_n           : clock (rising edge), synchronous active-low reset
//   in_valid/in_ready    : operand handshake; in_ready is the global advance
//   in_a, in_b           : operands {sign, exp, frac}
//   out_valid/out_ready  : result handshake
//   out_data             : product
//   out_flags            : {invalid, overflow, underflow}, aligned with out_data
// Build option: FP_MUL_RNE_EN selects round-to-nearest-even; without it the
// fraction is truncated.
module fp_mul_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] in_a,
  input  logic [EXP_W+MAN_W:0] in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] out_data,
  output logic [2:0]           out_flags
);

  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int BIAS = fp_bias(EXP_W);
  localparam int PW   = 2 * MAN_W + 2;
  localparam int XW   = EXP_W + 2;

  localparam logic signed [XW-1:0] BIAS_X = XW'(BIAS);
  localparam logic signed [XW-1:0] EMAX_X = XW'((1 << EXP_W) - 1);
  localparam logic signed [XW-1:0] ONE_X  = XW'(1);
  localparam logic signed [XW-1:0] ZERO_X = '0;
  localparam logic [W-1:0]         QNAN   = W'(fp_qnan(EXP_W, MAN_W));

`ifdef FP_MUL_RNE_EN
  localparam logic RNE = 1'b1;
`else
  localparam logic RNE = 1'b0;
`endif

  // Round-up decision; with RNE cleared the fraction is simply truncated.
  function automatic logic round_inc(input logic lsb, input logic g, input logic s);
    return RNE & g & (s | lsb);
  endfunction

  logic adv;
  assign adv      = !out_valid | out_ready;
  assign in_ready = adv;

  // ---------------------------------------------------------------- S1 input
  logic            sa, sb;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W:0]  ma, mb;
  fp_class_e       ca, cb;

  fp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_a (
    .op(in_a), .sign(sa), .expo(ea), .sig(ma), .cls(ca)
  );
  fp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_b (
    .op(in_b), .sign(sb), .expo(eb), .sig(mb), .cls(cb)
  );

  logic                 s_x;
  logic signed [XW-1:0] esum;
  logic                 spec;
  logic [W-1:0]         spec_data;
  logic [2:0]           spec_flags;

  always_comb begin
    s_x        = sa ^ sb;
    esum       = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS_X;
    spec       = 1'b1;
    spec_data  = '0;
    spec_flags = '0;
    if (ca == FP_NAN || cb == FP_NAN ||
        (ca == FP_ZERO && cb == FP_INF) || (ca == FP_INF && cb == FP_ZERO)) begin
      spec_data           = QNAN;
      spec_flags[FLG_INV] = 1'b1;
    end else if (ca == FP_INF || cb == FP_INF) begin
      spec_data = {s_x, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (ca == FP_ZERO || cb == FP_ZERO) begin
      spec_data = {s_x, {(W-1){1'b0}}};
    end else begin
      spec = 1'b0;
    end
  end

  logic                 vld_p1;
  logic                 sign_p1;
  logic signed [XW-1:0] exp_p1;
  logic [MAN_W:0]       siga_p1, sigb_p1;
  logic                 spec_p1;
  logic [W-1:0]         spec_data_p1;
  logic [2:0]           spec_flags_p1;

  // ---------------------------------------------------------------- S2 multiply
  logic                 vld_p2;
  logic                 sign_p2;
  logic signed [XW-1:0] exp_p2;
  logic [PW-1:0]        prod_p2;
  logic                 spec_p2;
  logic [W-1:0]         spec_data_p2;
  logic [2:0]           spec_flags_p2;

  always_ff @(posedge clk) begin
    if (adv) begin
      sign_p1       <= s_x;
      exp_p1        <= esum;
      siga_p1       <= ma;
      sigb_p1       <= mb;
      spec_p1       <= spec;
      spec_data_p1  <= spec_data;
      spec_flags_p1 <= spec_flags;

      sign_p2       <= sign_p1;
      exp_p2        <= exp_p1;
      prod_p2       <= {{(MAN_W+1){1'b0}}, siga_p1} * {{(MAN_W+1){1'b0}}, sigb_p1};
      spec_p2       <= spec_p1;
      spec_data_p2  <= spec_data_p1;
      spec_flags_p2 <= spec_flags_p1;
    end
  end

  // ---------------------------------------------------------------- S3 normalise/round/pack
  // pn drops the leading one: product in [1,4) is aligned so bit PW-2 is the
  // first fraction bit, with the exponent bumped when the product was >= 2.
  logic [PW-2:0]        pn;
  logic [MAN_W-1:0]     frac;
  logic                 g, st, inc;
  logic [MAN_W:0]       fr;
  logic signed [XW-1:0] e;
  logic [W-1:0]         res;
  logic [2:0]           flg;

  always_comb begin
    pn   = prod_p2[PW-1] ? prod_p2[PW-2:0] : {prod_p2[PW-3:0], 1'b0};
    e    = exp_p2 + (prod_p2[PW-1] ? ONE_X : ZERO_X);
    frac = pn[PW-2 -: MAN_W];
    g    = pn[MAN_W];
    st   = |pn[MAN_W-1:0];
    inc  = round_inc(frac[0], g, st);
    fr   = {1'b0, frac} + {{MAN_W{1'b0}}, inc};
    // Carry out of the fraction means 1.111..1 rounded to 10.0: fraction is
    // already zero, only the exponent moves.
    if (fr[MAN_W]) e = e + ONE_X;
    res = '0;
    flg = '0;
    if (spec_p2) begin
      res = spec_data_p2;
      flg = spec_flags_p2;
    end else if (e >= EMAX_X) begin
      res          = {sign_p2, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flg[FLG_OVF] = 1'b1;
    end else if (e <= ZERO_X) begin
      res          = {sign_p2, {(W-1){1'b0}}};
      flg[FLG_UDF] = 1'b1;
    end else begin
      res = {sign_p2, e[EXP_W-1:0], fr[MAN_W-1:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_flags <= '0;
    end else if (adv) begin
      vld_p1    <= in_valid;
      vld_p2    <= vld_p1;
      out_valid <= vld_p2;
      if (vld_p2) begin
        out_data  <= res;
        out_flags <= flg;
      end
    end
  end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Scoreboard bench for fp_mul_pipe (EXP_W=8, MAN_W=23) with directed vectors.
module tb_fp_mul_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic [2:0]  out_flags;

  always #5 clk = ~clk;

  fp_mul_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_flags(out_flags)
  );

`ifdef FP_MUL_RNE_EN
  localparam logic [31:0] TIE_RES = 32'h3FC00002;
`else
  localparam logic [31:0] TIE_RES = 32'h3FC00001;
`endif

  typedef struct {
    string       nm;
    logic [31:0] d;
    logic [2:0]  f;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          total = 0;
  int          bad = 0;
  int          n_out = 0;
  logic        hold_v = 1'b0;
  logic [31:0] hold_d;
  logic [2:0]  hold_f;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Monitor: pops one expectation per accepted result, watches stalls.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v && out_valid) begin
        chk("stall_data_stable", out_data, hold_d);
        chk("stall_flags_stable", out_flags, hold_f);
      end
      if (out_valid && !out_ready) begin
        chk("stall_in_ready", in_ready, 0);
        hold_v = 1'b1;
        hold_d = out_data;
        hold_f = out_flags;
      end else begin
        hold_v = 1'b0;
      end
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL stale_result actual=%h required=none", out_data);
        end else begin
          mon_e = exp_q.pop_front();
          chk({mon_e.nm, "_data"}, out_data, mon_e.d);
          chk({mon_e.nm, "_flags"}, out_flags, mon_e.f);
        end
      end
    end
  end

  // Offer an operand pair; returns at the negedge before the accepting edge.
  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] d, input logic [2:0] f, input string nm);
    int k;
    @(posedge clk); #1;
    in_a = a; in_b = b; in_valid = 1'b1;
    @(negedge clk);
    k = 0;
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL %s_accept actual=timeout required=in_ready", nm);
    end else begin
      exp_q.push_back('{nm, d, f});
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic op(input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] d, input logic [2:0] f, input string nm);
    send(a, b, d, f, nm);
    idle();
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() > 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain actual=%0d_pending required=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int k;
    int n0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_flags", out_flags, 0);
    chk("rst_in_ready", in_ready, 1);

    // 3.0 x 2.5 with latency measurement
    send(32'h40400000, 32'h40200000, 32'h40F00000, 3'b000, "mul_3x2p5");
    @(posedge clk); #1 in_valid = 1'b0;
    k = 1;
    @(negedge clk);
    while (!out_valid && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("latency", k, 3);
    drain();

    op(32'h3F800001, 32'h3FC00000, TIE_RES,      3'b000, "tie_round");
    op(32'h7F000000, 32'h40000000, 32'h7F800000, 3'b010, "overflow");
    op(32'h00800000, 32'h3F000000, 32'h00000000, 3'b001, "underflow");
    op(32'h7F800000, 32'h00000000, 32'h7FC00000, 3'b100, "inf_x_zero");
    op(32'h00000000, 32'hFF800000, 32'h7FC00000, 3'b100, "zero_x_ninf");
    op(32'h7FC00001, 32'h3F800000, 32'h7FC00000, 3'b100, "nan_in");
    op(32'hC0000000, 32'h00000000, 32'h80000000, 3'b000, "neg_x_zero");
    op(32'hFF800000, 32'h40000000, 32'hFF800000, 3'b000, "ninf_x_2");
    drain();

    // Back-to-back stream with a 4-cycle downstream stall
    n0 = n_out;
    fork
      begin
        send(32'h40000000, 32'h40000000, 32'h40800000, 3'b000, "bp0");
        send(32'h3FC00000, 32'h3FC00000, 32'h40100000, 3'b000, "bp1");
        send(32'h3F800000, 32'h3F800000, 32'h3F800000, 3'b000, "bp2");
        send(32'hC0000000, 32'h40400000, 32'hC0C00000, 3'b000, "bp3");
        send(32'h3F000000, 32'h3F000000, 32'h3E800000, 3'b000, "bp4");
        send(32'h40800000, 32'h3E800000, 32'h3F800000, 3'b000, "bp5");
        idle();
      end
      begin
        int j;
        j = 0;
        while (!out_valid && j < 50) begin
          @(negedge clk);
          j++;
        end
        @(posedge clk); #1 out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    repeat (3) @(negedge clk);
    chk("bp_result_count", n_out - n0, 6);

    // Reset with three operations in flight
    send(32'h40000000, 32'h40000000, 32'h40800000, 3'b000, "rst_op1");
    send(32'h40400000, 32'h40000000, 32'h40C00000, 3'b000, "rst_op2");
    @(posedge clk); #1;
    in_a = 32'h3F800000; in_b = 32'h40000000; in_valid = 1'b1; rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("post_rst_out_valid", out_valid, 0);
    chk("post_rst_in_ready", in_ready, 1);
    n0 = n_out;
    repeat (10) @(negedge clk);
    chk("post_rst_no_stale", n_out - n0, 0);
    op(32'h40400000, 32'h40400000, 32'h41100000, 3'b000, "post_rst_3x3");
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
